// File: rtl/instr_mem_banked_if.sv
// Fetch, bank-select and streaming-loader signals of the banked instruction memory.
// The master side drives requests and load data; the slave side is the memory.
interface instr_mem_banked_if #(
  parameter int W  = 9,
  parameter int D  = 10,
  parameter int NB = 4
);
  localparam int BW = $clog2(NB);

  logic [BW-1:0] bank_sel;
  logic          bank_go;
  logic [D-1:0]  prog_ctr;
  logic          fetch_en;
  logic [W-1:0]  mach_code;
  logic          code_valid;
  logic [BW-1:0] active_bank;
  logic          ld_start;
  logic [BW-1:0] ld_bank;
  logic [D-1:0]  ld_base;
  logic [D:0]    ld_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [W-1:0]  ld_data;
  logic          ld_done;
  logic          busy;

  modport master (
    output bank_sel, bank_go, prog_ctr, fetch_en,
    output ld_start, ld_bank, ld_base, ld_len, ld_valid, ld_data,
    input  mach_code, code_valid, active_bank, ld_ready, ld_done, busy
  );

  modport slave (
    input  bank_sel, bank_go, prog_ctr, fetch_en,
    input  ld_start, ld_bank, ld_base, ld_len, ld_valid, ld_data,
    output mach_code, code_valid, active_bank, ld_ready, ld_done, busy
  );
endinterface

// File: rtl/instr_mem_banked.sv
// Multi-bank instruction memory: registered fetch port from the active bank plus a
// streaming loader that can rewrite any bank; fetch stalls only while the active bank is loaded.
module instr_mem_banked #(
  parameter int W  = 9,
  parameter int D  = 10,
  parameter int NB = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  instr_mem_banked_if.slave bus
);
  localparam int BW    = $clog2(NB);
  localparam int LW    = D + 1;
  localparam int DEPTH = NB * (2 ** D);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

  ld_state_t     state;
  logic [W-1:0]  mem [DEPTH];
  logic [BW-1:0] ld_bank_q;
  logic [D-1:0]  ld_addr;
  logic [LW-1:0] ld_rem;
  logic          ld_ready_q;
  logic          ld_done_q;
  logic [BW-1:0] active_bank_q;
  logic [W-1:0]  mach_code_p1;
  logic          vld_p1;
  logic          busy_c;
  logic          wr_en;
  logic          fetch_go;

  assign busy_c   = (state == LOAD) && (ld_bank_q == active_bank_q);
  assign wr_en    = (state == LOAD) && ld_ready_q && bus.ld_valid;
  assign fetch_go = bus.fetch_en && !busy_c;

  // Storage is deliberately outside reset so program images survive a reset.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[{ld_bank_q, ld_addr}] <= bus.ld_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ld_bank_q  <= '0;
      ld_addr    <= '0;
      ld_rem     <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            ld_bank_q <= bus.ld_bank;
            ld_addr   <= bus.ld_base;
            ld_rem    <= bus.ld_len;
            if (bus.ld_len == '0) begin
              state     <= DONE;
              ld_done_q <= 1'b1;
            end else begin
              state      <= LOAD;
              ld_ready_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.ld_valid && ld_ready_q) begin
            ld_addr <= ld_addr + D'(1);
            ld_rem  <= ld_rem - LW'(1);
            if (ld_rem == LW'(1)) begin
              state      <= DONE;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          ld_done_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ld_ready_q <= 1'b0;
          ld_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch stage p1: a request in the same cycle as bank_go still reads the old bank.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bank_q <= '0;
      mach_code_p1  <= '0;
      vld_p1        <= 1'b0;
    end else begin
      if (bus.bank_go) begin
        active_bank_q <= bus.bank_sel;
      end
      vld_p1 <= fetch_go;
      if (fetch_go) begin
        mach_code_p1 <= mem[{active_bank_q, bus.prog_ctr}];
      end
    end
  end

  assign bus.mach_code   = mach_code_p1;
  assign bus.code_valid  = vld_p1;
  assign bus.active_bank = active_bank_q;
  assign bus.ld_ready    = ld_ready_q;
  assign bus.ld_done     = ld_done_q;
  assign bus.busy        = busy_c;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Bench for instr_mem_banked: fetch readback vectors from a table, fetch outputs checked
// against a scoreboard queue, hand-written sequences for load stalls, zero-length bursts and reset aborts.
module tb_instr_mem_banked;
  localparam int W     = 9;
  localparam int D     = 10;
  localparam int NB    = 4;
  localparam int BW    = $clog2(NB);
  localparam int LW    = D + 1;
  localparam int DEPTH = 2 ** D;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  instr_mem_banked_if #(.W(W), .D(D), .NB(NB)) bus ();

  instr_mem_banked #(.W(W), .D(D), .NB(NB)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int bank;
    int addr;
    int code;
  } vec_t;

  vec_t         vecs [20];
  int           checks = 0;
  int           errors = 0;
  int           sb [$];
  logic [W-1:0] model [NB][DEPTH];
  int           cur_bank = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Every valid fetch output must match the oldest outstanding expectation.
  initial begin : monitor
    forever begin
      @(posedge Clk);
      #2;
      if (bus.code_valid) begin
        if (sb.size() == 0) chk("fetch_unexpected", int'(bus.code_valid), 0);
        else chk("fetch_code", int'(bus.mach_code), sb.pop_front());
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic fetch(input int addr);
    bus.fetch_en = 1'b1;
    bus.prog_ctr = D'(addr);
    sb.push_back(int'(model[cur_bank][addr]));
  endtask

  task automatic drain(input string nm);
    bus.fetch_en = 1'b0;
    tick();
    tick();
    #2;
    chk(nm, sb.size(), 0);
  endtask

  task automatic switch_bank(input int b);
    bus.fetch_en = 1'b0;
    bus.bank_go  = 1'b1;
    bus.bank_sel = BW'(b);
    tick();
    bus.bank_go = 1'b0;
    cur_bank    = b;
    chk("active_bank", int'(bus.active_bank), b);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (vecs[i].bank != cur_bank) switch_bank(vecs[i].bank);
      bus.fetch_en = 1'b1;
      bus.prog_ctr = D'(vecs[i].addr);
      sb.push_back(vecs[i].code);
      tick();
      chk("fetch_valid", int'(bus.code_valid), 1);
    end
    drain("table_drain");
    chk("code_hold", int'(bus.mach_code), vecs[hi-1].code);
    chk("code_idle", int'(bus.code_valid), 0);
  endtask

  task automatic do_load(input int bank, input int base, input int len, input int first,
                         input bit toggle, input bit do_fetch, input bit noise);
    int n;
    int cyc;
    int fa;
    bit stall;
    bit v;
    n     = 0;
    cyc   = 0;
    fa    = 0;
    stall = (bank == cur_bank);
    bus.ld_start = 1'b1;
    bus.ld_bank  = BW'(bank);
    bus.ld_base  = D'(base);
    bus.ld_len   = LW'(len);
    if (do_fetch) begin
      fetch(fa);
      fa = (fa + 1) % 4;
    end
    tick();
    bus.ld_start = 1'b0;
    while (n < len && cyc < 64) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.ld_valid = v;
      bus.ld_data  = W'(first + n);
      chk("ld_ready", int'(bus.ld_ready), 1);
      chk("busy", int'(bus.busy), int'(stall));
      if (noise && cyc == 1) begin
        bus.ld_start = 1'b1;
        bus.ld_bank  = BW'(bank + 1);
        bus.ld_base  = D'(base + 7);
        bus.ld_len   = LW'(1);
      end else begin
        bus.ld_start = 1'b0;
      end
      if (do_fetch) begin
        chk("code_valid_ld", int'(bus.code_valid), (stall && cyc > 0) ? 0 : 1);
        if (stall) begin
          bus.fetch_en = 1'b1;
          bus.prog_ctr = D'(fa);
        end else begin
          fetch(fa);
        end
        fa = (fa + 1) % 4;
      end
      tick();
      if (v) begin
        model[bank][(base + n) % DEPTH] = W'(first + n);
        n++;
      end
      cyc++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_start = 1'b0;
    chk("ld_done", int'(bus.ld_done), 1);
    chk("ld_ready_done", int'(bus.ld_ready), 0);
    chk("busy_done", int'(bus.busy), 0);
    if (do_fetch) begin
      chk("code_valid_done", int'(bus.code_valid), stall ? 0 : 1);
      fetch(fa);
    end
    tick();
    chk("ld_done_pulse", int'(bus.ld_done), 0);
    if (do_fetch) begin
      chk("fetch_resume", int'(bus.code_valid), 1);
      drain("load_drain");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mach_code"}, int'(bus.mach_code), 0);
    chk({tag, "_code_valid"}, int'(bus.code_valid), 0);
    chk({tag, "_active_bank"}, int'(bus.active_bank), 0);
    chk({tag, "_ld_ready"}, int'(bus.ld_ready), 0);
    chk({tag, "_ld_done"}, int'(bus.ld_done), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin : main
    vecs[0]  = '{1, 'h000, 'h001};
    vecs[1]  = '{1, 'h001, 'h002};
    vecs[2]  = '{1, 'h002, 'h003};
    vecs[3]  = '{1, 'h003, 'h004};
    vecs[4]  = '{2, 'h3FE, 'h0A0};
    vecs[5]  = '{2, 'h3FF, 'h0A1};
    vecs[6]  = '{2, 'h000, 'h0A2};
    vecs[7]  = '{0, 'h004, 'h104};
    vecs[8]  = '{0, 'h005, 'h105};
    vecs[9]  = '{0, 'h020, 'h0D0};
    vecs[10] = '{0, 'h021, 'h0D1};
    vecs[11] = '{0, 'h022, 'h0D2};
    vecs[12] = '{0, 'h023, 'h0D3};
    vecs[13] = '{0, 'h000, 'h100};
    vecs[14] = '{0, 'h001, 'h101};
    vecs[15] = '{3, 'h010, 'h0C0};
    vecs[16] = '{3, 'h011, 'h0C1};
    vecs[17] = '{3, 'h012, 'h1E2};
    vecs[18] = '{3, 'h013, 'h1E3};
    vecs[19] = '{3, 'h014, 'h1E4};

    bus.bank_sel = '0;
    bus.bank_go  = 1'b0;
    bus.prog_ctr = '0;
    bus.fetch_en = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_bank  = '0;
    bus.ld_base  = '0;
    bus.ld_len   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;

    Reset_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    Reset_n = 1'b1;
    tick();

    do_load(0, 'h000, 8, 'h100, 1'b0, 1'b0, 1'b0);
    do_load(1, 'h000, 4, 'h001, 1'b0, 1'b0, 1'b0);
    do_load(2, 'h3FE, 3, 'h0A0, 1'b0, 1'b0, 1'b0);
    run_table(0, 9);

    // Fetch issued together with bank_go must come from the old bank.
    bus.bank_go  = 1'b1;
    bus.bank_sel = BW'(1);
    fetch(2);
    tick();
    bus.bank_go = 1'b0;
    cur_bank    = 1;
    fetch(2);
    tick();
    drain("bank_go_drain");
    chk("bank_go_active", int'(bus.active_bank), 1);

    switch_bank(0);
    do_load(3, 'h010, 5, 'h1E0, 1'b0, 1'b1, 1'b0);
    do_load(0, 'h020, 4, 'h0D0, 1'b1, 1'b1, 1'b1);

    // Zero-length burst, with a second start held through DONE.
    bus.ld_start = 1'b1;
    bus.ld_bank  = '0;
    bus.ld_base  = '0;
    bus.ld_len   = '0;
    tick();
    chk("len0_done", int'(bus.ld_done), 1);
    chk("len0_ready", int'(bus.ld_ready), 0);
    bus.ld_len   = LW'(2);
    bus.ld_valid = 1'b1;
    bus.ld_data  = W'('h1FF);
    tick();
    bus.ld_start = 1'b0;
    chk("len0_done_pulse", int'(bus.ld_done), 0);
    chk("len0_restart_ignored", int'(bus.ld_ready), 0);
    tick();
    chk("len0_idle_ready", int'(bus.ld_ready), 0);
    chk("len0_idle_done", int'(bus.ld_done), 0);
    bus.ld_valid = 1'b0;

    // Reset two words into a five-word burst to bank 3.
    switch_bank(2);
    bus.ld_start = 1'b1;
    bus.ld_bank  = BW'(3);
    bus.ld_base  = D'('h010);
    bus.ld_len   = LW'(5);
    fetch('h3FE);
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = W'('h0C0);
    fetch('h3FF);
    tick();
    bus.ld_data = W'('h0C1);
    fetch('h3FE);
    tick();
    bus.ld_data  = W'('h0C2);
    bus.fetch_en = 1'b0;
    #3;
    chk("pre_reset_valid", int'(bus.code_valid), 1);
    chk("pre_reset_ready", int'(bus.ld_ready), 1);
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    tick();
    Reset_n = 1'b1;
    model[3]['h010] = W'('h0C0);
    model[3]['h011] = W'('h0C1);
    cur_bank = 0;
    tick();
    chk("abort_no_done", int'(bus.ld_done), 0);
    chk("abort_idle_ready", int'(bus.ld_ready), 0);
    tick();
    chk("abort_no_done_late", int'(bus.ld_done), 0);
    bus.ld_valid = 1'b0;
    chk("abort_sb_empty", sb.size(), 0);

    run_table(9, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
